// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, funct codes,
// ALU select codes and the controller state enumeration.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU select code. Unknown funct values fall back to ADD.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_sel
);

  // Pure lookup from funct to ALU operation
  always_comb begin
    o_alu_sel = ALU_ADD;
    case (i_funct)
      FN_ADD:  o_alu_sel = ALU_ADD;
      FN_SUB:  o_alu_sel = ALU_SUB;
      FN_AND:  o_alu_sel = ALU_AND;
      FN_OR:   o_alu_sel = ALU_OR;
      FN_NOR:  o_alu_sel = ALU_NOR;
      FN_SLT:  o_alu_sel = ALU_SLT;
      default: o_alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller. Moore FSM sequencing fetch, decode and
// per-instruction execute/writeback steps; all outputs forced low in reset.
//
//  state  | meaning
//  FETCH  | IR <- mem[PC], PC <- PC+4
//  DECODE | compute branch target, dispatch on opcode (illegal retires here)
//  MEMADR | effective address = A + sign-ext imm
//  MEMRD  | read data memory
//  MEMWB  | write loaded word to rt (lw retires)
//  MEMWR  | write B to data memory (sw retires)
//  EXEC   | R-type ALU operation selected by funct
//  ALUWB  | write ALU result to rd (R-type retires)
//  BRANCH | compare A-B, load PC from ALUOut when zero (beq retires)
//  ADDIEX | A + sign-ext imm
//  ADDIWB | write result to rt (addi retires)
//  JUMP   | PC <- jump target (j retires)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] w_funct_sel;
  logic       w_pc_write;
  logic       w_branch;

  alu_decoder u_alu_decoder (
    .i_funct   (funct),
    .o_alu_sel (w_funct_sel)
  );

  // State register; reset always returns to FETCH, even mid-instruction
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state; terminal states and unreachable encodings return to FETCH
  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_RTYPE:     w_state_nxt = S_EXEC;
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_ADDI:      w_state_nxt = S_ADDIEX;
          OP_J:         w_state_nxt = S_JUMP;
          default:      w_state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: w_state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_state_nxt = S_MEMWB;
      S_EXEC:   w_state_nxt = S_ALUWB;
      S_ADDIEX: w_state_nxt = S_ADDIWB;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // Output decode from state; reset gates everything to 0 combinationally
  always_comb begin
    alu_sel    = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          ir_write   = 1'b1;
          w_pc_write = 1'b1;
          alu_src_b  = 2'b01;
          alu_sel    = ALU_ADD;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          alu_sel    = ALU_ADD;
          instr_done = !is_legal_op(opcode);
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_sel   = ALU_ADD;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_sel   = w_funct_sel;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_sel    = ALU_SUB;
          pc_src     = 2'b01;
          w_branch   = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          w_pc_write = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = w_pc_write | (w_branch & zero);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl against an
// instruction-level model of expected per-cycle control outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, instr_done;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .alu_sel    (alu_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // [15:13] alu_sel [12] src_a [11:10] src_b [9:8] pc_src
  // [7] pc_en [6] ir_write [5] mem_write [4] iord [3] reg_write
  // [2] reg_dst [1] mem_to_reg [0] instr_done
  logic [15:0] dut_vec;
  assign dut_vec = {alu_sel, alu_src_a, alu_src_b, pc_src, pc_en, ir_write,
                    mem_write, iord, reg_write, reg_dst, mem_to_reg, instr_done};

  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic [15:0] exp_vec = 16'h0000;
  logic [15:0] obs [0:7];

  function automatic logic legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
           op == 6'h23 || op == 6'h2B;
  endfunction

  function automatic int len_of(input logic [5:0] op);
    case (op)
      6'h23:   return 5;
      6'h2B:   return 4;
      6'h00:   return 4;
      6'h08:   return 4;
      6'h04:   return 3;
      6'h02:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] fmap(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h27:   return 3'b100;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle 'step' of an instruction, from the
  // per-instruction micro-step description.
  function automatic logic [15:0] model(input logic [5:0] op, input logic [5:0] fn,
                                         input int step, input logic z);
    logic [2:0] a;
    logic sa, pe, irw, mw, io, rw, rd, m2r, dn;
    logic [1:0] sb, ps;
    a = 3'b000; sa = 0; sb = 2'b00; ps = 2'b00;
    pe = 0; irw = 0; mw = 0; io = 0; rw = 0; rd = 0; m2r = 0; dn = 0;
    if (step == 0) begin
      a = 3'b010; sb = 2'b01; irw = 1; pe = 1;
    end else if (step == 1) begin
      a = 3'b010; sb = 2'b11; dn = !legal(op);
    end else begin
      case (op)
        6'h23: begin
          if (step == 2) begin sa = 1; sb = 2'b10; a = 3'b010; end
          else if (step == 3) io = 1;
          else begin rw = 1; m2r = 1; dn = 1; end
        end
        6'h2B: begin
          if (step == 2) begin sa = 1; sb = 2'b10; a = 3'b010; end
          else begin io = 1; mw = 1; dn = 1; end
        end
        6'h00: begin
          if (step == 2) begin sa = 1; a = fmap(fn); end
          else begin rw = 1; rd = 1; dn = 1; end
        end
        6'h08: begin
          if (step == 2) begin sa = 1; sb = 2'b10; a = 3'b010; end
          else begin rw = 1; dn = 1; end
        end
        6'h04: begin sa = 1; a = 3'b110; ps = 2'b01; pe = z; dn = 1; end
        default: begin pe = 1; ps = 2'b10; dn = 1; end
      endcase
    end
    return {a, sa, sb, ps, pe, irw, mw, io, rw, rd, m2r, dn};
  endfunction

  // Single per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL cycle_out t=%0t op=%h fn=%h rst=%b got=%b exp=%b",
                 $time, opcode, funct, reset, dut_vec, exp_vec);
      end
    end
  end

  task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", name, act, req);
    end
  endtask

  // Drive one instruction; abort_at >= 0 asserts reset in that step instead.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    int n;
    n = len_of(op);
    for (int i = 0; i < 8; i++) obs[i] = 16'hxxxx;
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      #1;
      if (s == abort_at) begin
        reset   = 1'b1;
        opcode  = 6'($urandom);
        funct   = 6'($urandom);
        zero    = 1'($urandom);
        exp_vec = 16'h0000;
        @(negedge clk);
        obs[s] = dut_vec;
        return;
      end
      reset  = 1'b0;
      opcode = (s == 1 || (s == 2 && (op == 6'h23 || op == 6'h2B))) ? op : 6'($urandom);
      funct  = (s == 2 && op == 6'h00) ? fn : 6'($urandom);
      zero   = (zmode < 0) ? 1'($urandom) : zmode[0];
      exp_vec = model(op, fn, s, zero);
      @(negedge clk);
      obs[s] = dut_vec;
    end
  endtask

  localparam logic [15:0] V_FETCH = 16'b010_0_01_00_1100_0000;
  localparam logic [15:0] V_MEMWB = 16'b000_0_00_00_0000_1011;

  initial begin
    logic [5:0] ops [0:5];
    logic [5:0] fns [0:5];
    logic [5:0] op, fn;
    int dones;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    chk_en = 1'b1;
    @(negedge clk);
    check_lit("reset_zero_c1", dut_vec, 16'h0000);
    @(negedge clk);
    check_lit("reset_zero_c2", dut_vec, 16'h0000);

    // lw right after reset release
    run_instr(6'h23, 6'h00, -1, -1);
    check_lit("release_fetch", obs[0], V_FETCH);
    check_lit("lw_memwb", obs[4], V_MEMWB);
    dones = 0;
    for (int i = 0; i < 5; i++) dones += int'(obs[i][0]);
    check_lit("lw_done_count", 16'(dones), 16'd1);

    run_instr(6'h00, 6'h22, -1, -1);
    check_lit("rtype_sub_sel", 16'(obs[2][15:13]), 16'(3'b110));
    check_lit("rtype_aluwb_regdst", 16'(obs[3][2]), 16'd1);
    run_instr(6'h00, 6'h2A, -1, -1);
    check_lit("rtype_slt_sel", 16'(obs[2][15:13]), 16'(3'b111));
    run_instr(6'h00, 6'h27, -1, -1);
    check_lit("rtype_nor_sel", 16'(obs[2][15:13]), 16'(3'b100));

    run_instr(6'h04, 6'h00, 1, -1);
    check_lit("beq_taken", 16'({obs[2][9:8], obs[2][7]}), 16'(3'b011));
    run_instr(6'h04, 6'h00, 0, -1);
    check_lit("beq_not_taken", 16'(obs[2][7]), 16'd0);

    run_instr(6'h3F, 6'h00, -1, -1);
    check_lit("illegal_done", 16'(obs[1][0]), 16'd1);
    check_lit("illegal_no_wr", 16'({obs[0][5], obs[0][3], obs[1][5], obs[1][3]}), 16'd0);
    run_instr(6'h02, 6'h00, -1, -1);
    check_lit("fetch_after_illegal", obs[0], V_FETCH);

    run_instr(6'h2B, 6'h00, -1, -1);
    check_lit("sw_memwr", 16'({obs[3][5], obs[3][4], obs[3][0]}), 16'(3'b111));
    run_instr(6'h2B, 6'h00, -1, 3);
    check_lit("sw_reset_drop", obs[3], 16'h0000);
    run_instr(6'h08, 6'h00, -1, -1);
    check_lit("fetch_after_reset", obs[0], V_FETCH);

    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = $urandom_range(0, 6);
      if (sel < 6) op = ops[sel];
      else begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0)
        run_instr(op, fn, -1, $urandom_range(0, len_of(op) - 1));
      else
        run_instr(op, fn, -1, -1);
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 The block SHALL have these data and control inputs: opcode in 6, instruction [31:26] from the IR; funct in 6, instruction [5:0]; zero in 1, ALU Z flag.
REQ-003 The block SHALL have these outputs: alu_sel out 3, ALU select code; alu_src_a out 1, 0=PC / 1=reg A; alu_src_b out 2, 00=reg B / 01=const 4 / 10=sign-ext imm / 11=imm<<2; pc_src out 2, 00=ALU result / 01=ALUOut reg / 10=jump target.
REQ-004 The block SHALL have these strobe outputs: pc_en out 1, PC load enable; ir_write out 1; mem_write out 1; iord out 1, 1=data address; reg_write out 1; reg_dst out 1, 1=rd; mem_to_reg out 1; instr_done out 1, one-cycle retire pulse.

Function
REQ-005 alu_sel SHALL use the ALU encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111, NOR 100.
REQ-006 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, held in a registered state variable.
REQ-007 FETCH SHALL assert ir_write and pc_write with alu_src_a=0, alu_src_b=01, alu_sel=ADD, pc_src=00, then go to DECODE.
REQ-008 DECODE SHALL compute the branch target (alu_src_a=0, alu_src_b=11, ADD) and dispatch on opcode: 0x23/0x2B->MEMADR; 0x00->EXEC; 0x04->BRANCH; 0x08->ADDIEX; 0x02->JUMP; any other->FETCH with no write strobe.
REQ-009 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, ADD, then go to MEMRD for 0x23 or to MEMWR for 0x2B.
REQ-010 MEMRD SHALL assert iord then go to MEMWB.
REQ-011 MEMWB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-012 MEMWR SHALL assert iord and mem_write, then go to FETCH.
REQ-013 EXEC SHALL drive alu_src_a=1, alu_src_b=00, with alu_sel from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, any other ADD; it SHALL then go to ALUWB.
REQ-014 ALUWB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-015 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, SUB, pc_src=01 and pc_en=zero, then go to FETCH.
REQ-016 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, ADD, then go to ADDIWB.
REQ-017 ADDIWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-018 JUMP SHALL assert pc_en with pc_src=10, then go to FETCH.
REQ-019 pc_en SHALL equal pc_write OR (branch AND zero), where pc_write and branch are internal decodes of the state.
REQ-020 Outputs SHALL be Moore, decoded from the state only, except pc_en, which also uses zero.
REQ-021 In any state, outputs not named for that state SHALL be 0.
REQ-022 instr_done SHALL pulse in the last state of each instruction: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, and DECODE for an illegal opcode.
REQ-023 Instruction latency in cycles SHALL be: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
REQ-024 opcode and funct SHALL be sampled only in DECODE, MEMADR and EXEC; changes to them in other states SHALL have no effect.
REQ-025 An unreachable state encoding SHALL transition to FETCH on the next clock edge.

Reset
REQ-026 With reset high at a rising clock edge, the state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-027 While reset is high, every strobe output (pc_en, ir_write, mem_write, reg_write, instr_done) SHALL be forced to 0.
REQ-028 While reset is high, all select outputs SHALL be 0.
REQ-029 On the first edge after reset deasserts, FETCH SHALL execute normally.

Structure
REQ-030 A shared package SHALL hold the opcode constants, funct constants, ALU select codes and the state enumeration; the ALU shall use the same select constants.
REQ-031 The funct-to-alu_sel mapping SHALL be a separate combinational sub-module alu_decoder, instantiated once.

Verification
REQ-032 Reset for 2 cycles, then release -> all strobes are 0 during reset; the cycle after release shows ir_write=1, pc_en=1, alu_sel=010.
REQ-033 lw (opcode 0x23) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5; instr_done pulses once.
REQ-034 R-type with funct 0x22, then 0x2A, then 0x27 -> alu_sel in EXEC is 110, 111, 100 respectively; ALUWB has reg_dst=1.
REQ-035 beq (0x04) with zero=1 and then with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 for the second.
REQ-036 Illegal opcode 0x3F -> returns to FETCH after DECODE, with no mem_write or reg_write ever asserted.
REQ-037 reset asserted during MEMWR -> mem_write drops in the same cycle; the state is FETCH on the next edge.
